round_referee: RTL
==================

ROUND_REFEREE -- requirements
Module: round_referee

Interface
REQ-001 The module SHALL take parameter HOLD_CYCLES, default 4, which sets the number of cycles roundWin stays high after a non-final point (legal range 1..15).
REQ-002 The module SHALL take parameter WIN_SCORE, default 7, which sets the score that ends the match (legal range 1..7).
REQ-003 The module SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The module SHALL have port L, input, 1 bit: left-key press pulse, one cycle per press, already synchronised.
REQ-006 The module SHALL have port R, input, 1 bit: right-key press pulse, one cycle per press, already synchronised.
REQ-007 The module SHALL have port leftEdgeOn, input, 1 bit: the leftmost playfield light is lit.
REQ-008 The module SHALL have port rightEdgeOn, input, 1 bit: the rightmost playfield light is lit.
REQ-009 The module SHALL have port roundWin, output, 1 bit: forces every playfield light off.
REQ-010 The module SHALL have port newRound, output, 1 bit: one-cycle pulse, ORed into the playfield reset at top level to relight the centre light.
REQ-011 The module SHALL have port leftScore, output, 3 bits: left player point count.
REQ-012 The module SHALL have port rightScore, output, 3 bits: right player point count.
REQ-013 The module SHALL have port gameOver, output, 1 bit: the match has ended.
REQ-014 The module SHALL have port hexL, output, 7 bits: active-low seven-segment code for leftScore, bit order gfedcba.
REQ-015 The module SHALL have port hexR, output, 7 bits: active-low seven-segment code for rightScore, bit order gfedcba.

Function
REQ-016 The module SHALL implement three states: PLAY, HOLD and OVER.
REQ-017 In PLAY, a left point SHALL occur when L && !R && leftEdgeOn.
REQ-018 In PLAY, a right point SHALL occur when R && !L && rightEdgeOn.
REQ-019 When L and R are high in the same cycle, or a key is pressed with no edge light lit, no point SHALL occur.
REQ-020 If leftEdgeOn and rightEdgeOn are both high, only the qualifying key SHALL score, and at most one point SHALL be awarded per cycle.
REQ-021 On a point, the scorer's count SHALL increment by 1 on the same clock edge.
REQ-022 If the new count equals WIN_SCORE, the next state SHALL be OVER; otherwise the next state SHALL be HOLD with the hold counter loaded to HOLD_CYCLES-1.
REQ-023 roundWin SHALL be registered and high in every cycle the state is HOLD or OVER, i.e. one cycle after the qualifying input.
REQ-024 In HOLD, the hold counter SHALL decrement each cycle; when it reaches 0, the next state SHALL be PLAY and newRound SHALL be high for exactly that one following cycle.
REQ-025 In HOLD and OVER, L and R SHALL be ignored.
REQ-026 OVER SHALL be absorbing: roundWin and gameOver stay high, scores stay frozen, and newRound stays low, until reset.
REQ-027 Score counters SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-028 hexL and hexR SHALL be combinational decodes of the score registers for digits 0-7.
REQ-029 When gameOver is high, the losing player's display SHALL be blank (7'b1111111) and the winner's display SHALL keep showing its digit.

Reset
REQ-030 On reset, the state SHALL be PLAY, both scores 0, and the hold counter 0.
REQ-031 On reset, roundWin=0, newRound=0, gameOver=0, and hexL=hexR=7'b1000000 (digit 0).
REQ-032 Reset SHALL take priority over all other inputs, including when asserted in HOLD or OVER; the state returns to PLAY in the next cycle.

Verification
REQ-033 Reset, then leftEdgeOn=1 with an L pulse -> next cycle leftScore=1 and roundWin=1 for 4 cycles; newRound pulses once in the cycle after roundWin falls; hexL=7'b1111001.
REQ-034 leftEdgeOn=1 with L=R=1 in the same cycle, then rightEdgeOn=0 with an R pulse -> no score change, roundWin stays 0.
REQ-035 L pulses during HOLD with leftEdgeOn=1 -> leftScore unchanged.
REQ-036 Seven right points via rightEdgeOn and R -> after the 7th, rightScore=7, gameOver=1, roundWin held high, hexL blank, hexR=7'b1111000; further R pulses have no effect.
REQ-037 Reset asserted two cycles into HOLD -> next cycle state PLAY, scores 0, roundWin=0, and no newRound pulse.
REQ-038 Instance with HOLD_CYCLES=1 and WIN_SCORE=2 -> roundWin is high for 1 cycle per point, and the 2nd point enters OVER directly with no newRound pulse.

Source files
------------

// File: rtl/round_referee.sv
// round_referee: decides points for a two-player reaction game, blanks the
// playfield between points, counts scores up to WIN_SCORE and drives two
// seven-segment score displays.
module round_referee #(
    parameter int HOLD_CYCLES = 4,   // cycles the playfield stays dark after a point (1..15)
    parameter int WIN_SCORE   = 7    // score that ends the match (1..7)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       leftEdgeOn,
    input  logic       rightEdgeOn,
    output logic       roundWin,
    output logic       newRound,
    output logic [2:0] leftScore,
    output logic [2:0] rightScore,
    output logic       gameOver,
    output logic [6:0] hexL,
    output logic [6:0] hexR
);

    // Encoding chosen so that roundWin and gameOver are plain state-register
    // bits: bit0 = playfield dark (HOLD or OVER), bit1 = match finished.
    localparam logic [1:0] ST_PLAY = 2'b00;
    localparam logic [1:0] ST_HOLD = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b11;

    localparam logic [2:0] WIN_VAL   = 3'(WIN_SCORE);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    logic [1:0] r_state;
    logic [3:0] r_hold_cnt;
    logic [2:0] r_left_score;
    logic [2:0] r_right_score;
    logic       r_new_round;

    logic       w_left_point;
    logic       w_right_point;
    logic [2:0] w_left_next;
    logic [2:0] w_right_next;

    // A point needs exactly one key and that player's edge light; simultaneous
    // presses cancel. Keys are only looked at while the round is live.
    assign w_left_point  = (r_state == ST_PLAY) && L && !R && leftEdgeOn;
    assign w_right_point = (r_state == ST_PLAY) && R && !L && rightEdgeOn;
    assign w_left_next   = r_left_score + 3'd1;
    assign w_right_next  = r_right_score + 3'd1;

    // Match sequencing: score on a point, dark-hold countdown, absorbing end state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_PLAY;
            r_hold_cnt    <= 4'd0;
            r_left_score  <= 3'd0;
            r_right_score <= 3'd0;
            r_new_round   <= 1'b0;
        end else begin
            r_new_round <= 1'b0;
            case (r_state)
                ST_PLAY: begin
                    if (w_left_point) begin
                        r_left_score <= w_left_next;
                        if (w_left_next == WIN_VAL) begin
                            r_state <= ST_OVER;
                        end else begin
                            r_state    <= ST_HOLD;
                            r_hold_cnt <= HOLD_LOAD;
                        end
                    end else if (w_right_point) begin
                        r_right_score <= w_right_next;
                        if (w_right_next == WIN_VAL) begin
                            r_state <= ST_OVER;
                        end else begin
                            r_state    <= ST_HOLD;
                            r_hold_cnt <= HOLD_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == 4'd0) begin
                        r_state     <= ST_PLAY;
                        r_new_round <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 4'd1;
                    end
                end
                ST_OVER: begin
                    r_state <= ST_OVER;
                end
                default: begin
                    r_state <= ST_PLAY;
                end
            endcase
        end
    end

    assign roundWin   = r_state[0];
    assign gameOver   = r_state[1];
    assign newRound   = r_new_round;
    assign leftScore  = r_left_score;
    assign rightScore = r_right_score;

    // Both displays share one decoder; index 0 is left, 1 is right.
    logic [2:0] w_score [2];
    logic [6:0] w_hex   [2];

    assign w_score[0] = r_left_score;
    assign w_score[1] = r_right_score;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_disp
            // Active-low gfedcba decode; the loser's display goes blank once the match ends.
            always_comb begin
                w_hex[gi] = 7'b1111111;
                if (!(r_state[1] && (w_score[gi] != WIN_VAL))) begin
                    case (w_score[gi])
                        3'd0:    w_hex[gi] = 7'b1000000;
                        3'd1:    w_hex[gi] = 7'b1111001;
                        3'd2:    w_hex[gi] = 7'b0100100;
                        3'd3:    w_hex[gi] = 7'b0110000;
                        3'd4:    w_hex[gi] = 7'b0011001;
                        3'd5:    w_hex[gi] = 7'b0010010;
                        3'd6:    w_hex[gi] = 7'b0000010;
                        default: w_hex[gi] = 7'b1111000;
                    endcase
                end
            end
        end
    endgenerate

    assign hexL = w_hex[0];
    assign hexR = w_hex[1];

endmodule
